// File: rtl/reservation_station.sv
// Reservation station: holds renamed ops until both sources are ready,
// snoops one CDB wakeup port per cycle and issues the lowest-index
// operand-ready op to its functional unit.
//
// Entry layout shared with dispatch/rename and the functional units.
package rs_pkg;

  localparam int RS_PREG_W = 7;

  typedef struct packed {
    logic [5:0]           opcode;
    logic [5:0]           rob_idx;
    logic [RS_PREG_W-1:0] prd;
    logic                 rs1_used;
    logic [RS_PREG_W-1:0] prs1;
    logic                 prs1_ready;
    logic                 rs2_used;
    logic [RS_PREG_W-1:0] prs2;
    logic                 prs2_ready;
  } rs_entry_t;

endpackage

// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_valid_i/ready_o: ready_o is computed from registered
// occupancy only; valid while not ready is ignored. issue_valid_o/
// issue_ready_i: issue_valid_o never depends on issue_ready_i, and the
// selected entry may change while stalled if a lower slot becomes eligible.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PREG_W = rs_pkg::RS_PREG_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  rs_entry_t         in_entry_i,
  output logic              ready_o,
  input  logic              cdb_valid_i,
  input  logic [PREG_W-1:0] cdb_tag_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output rs_entry_t         issue_entry_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Slot storage
  logic      [DEPTH-1:0] valid_q, valid_d;
  rs_entry_t             entry_q [DEPTH];
  rs_entry_t             entry_d [DEPTH];
  logic      [CNT_W-1:0] count_q, count_d;

  // Selection / allocation signals
  logic [DEPTH-1:0] eligible;
  logic             any_eligible;
  logic [IDX_W-1:0] sel_idx;
  logic             any_free;
  logic [IDX_W-1:0] free_idx;
  logic             do_insert;
  logic             do_issue;
  logic             cdb_hit_en;

  // Apply a CDB broadcast to one entry: set the ready bit of every used
  // source whose tag matches.
  function automatic rs_entry_t wake(input rs_entry_t e,
                                     input logic en,
                                     input logic [PREG_W-1:0] tag);
    rs_entry_t r;
    r = e;
    if (en && e.rs1_used && (e.prs1 == tag)) r.prs1_ready = 1'b1;
    if (en && e.rs2_used && (e.prs2 == tag)) r.prs2_ready = 1'b1;
    return r;
  endfunction

  // An entry may issue once every used source is ready.
  function automatic logic operands_ready(input rs_entry_t e);
    return (!e.rs1_used || e.prs1_ready) && (!e.rs2_used || e.prs2_ready);
  endfunction

  // Per-slot eligibility from registered state only.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = valid_q[i] && operands_ready(entry_q[i]);
    end
  end

  // Lowest-index eligible slot (scan high to low so the lowest wins).
  always_comb begin
    sel_idx      = '0;
    any_eligible = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_idx      = IDX_W'(i);
        any_eligible = 1'b1;
      end
    end
  end

  // Lowest-index free slot, from pre-edge valid bits.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // Handshake qualification; flush suppresses insert, issue and wakeup.
  always_comb begin
    ready_o       = (count_q != CNT_W'(DEPTH));
    issue_valid_o = any_eligible && !flush_i;
    do_insert     = in_valid_i && ready_o && any_free && !flush_i;
    do_issue      = issue_valid_o && issue_ready_i;
    cdb_hit_en    = cdb_valid_i && !flush_i;
    count_o       = count_q;
  end

  // Issue payload: selected slot with source ready bits forced high,
  // zero when nothing is eligible.
  always_comb begin
    issue_entry_o = '0;
    if (any_eligible) begin
      issue_entry_o            = entry_q[sel_idx];
      issue_entry_o.prs1_ready = 1'b1;
      issue_entry_o.prs2_ready = 1'b1;
    end
  end

  // Next slot state: wakeup on held entries, issue clears, insert writes a
  // woken copy of the incoming entry so a same-cycle broadcast is not lost.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = wake(entry_q[i], cdb_hit_en && valid_q[i], cdb_tag_i);
    end
    if (do_issue) begin
      valid_d[sel_idx] = 1'b0;
    end
    if (do_insert) begin
      valid_d[free_idx] = 1'b1;
      entry_d[free_idx] = wake(in_entry_i, cdb_hit_en, cdb_tag_i);
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Occupancy: +1 on insert, -1 on issue, cleared by flush.
  always_comb begin
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(do_insert) - CNT_W'(do_issue);
    end
  end

  // Slot and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule
